cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_pkg.sv | 18 +
 rtl/run_cycle_counter.sv | 37 +++
 rtl/cpu_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg -- shared definitions for the CPU run controller.
//   run_state_e : 2-bit controller state encoding (IDLE=0, RST=1, RUN=2, DONE=3)
//   DEF_*       : default parameter values used by cpu_run_ctrl
package cpu_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  localparam int          DEF_WIDTH        = 16;
  localparam int          DEF_CNT_W        = 32;
  localparam int          DEF_RESET_CYCLES = 2;
  localparam int unsigned DEF_TIMEOUT      = 65535;

endpackage

// File: rtl/run_cycle_counter.sv
// run_cycle_counter -- saturating, clearable cycle counter.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset, clears the count
//   clr      : synchronous clear (takes precedence over en)
//   en       : count one cycle
//   count    : registered count value
//   at_limit : the value the next enabled cycle would produce equals LIMIT
module run_cycle_counter #(
  parameter int          CNT_W = 32,
  parameter int unsigned LIMIT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_inc;

  // Saturate at all-ones instead of wrapping.
  assign w_inc    = (&r_count) ? r_count : r_count + CNT_W'(1);
  assign at_limit = (w_inc == CNT_W'(LIMIT));
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_inc;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl -- runs a CPU once per start request: holds the CPU in reset
// for RESET_CYCLES, releases it, and watches cpu_out until it equals the
// latched expect_val or TIMEOUT run cycles elapse.
// Optional feature macro: CPU_RUN_CTRL_ABORT_EN adds an abort input.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   start             : run request, sampled only in IDLE
//   arg, expect_val   : latched on an accepted start
//   cpu_in, cpu_reset : drive the CPU
//   cpu_out           : registered CPU output
//   busy, done, pass  : status (busy in RST/RUN, done one-cycle pulse)
//   result, cycles    : cpu_out at finish and RUN-cycle count of last run
//   abort             : (macro only) end the run without a pass
//   dbg_state         : current controller state
// Handshake: start is a level request; it is accepted on any clock edge where
// the controller is IDLE, and each accepted start yields exactly one done
// pulse. Starts seen while busy or in DONE are dropped, not queued.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int          WIDTH        = DEF_WIDTH,
  parameter int          CNT_W        = DEF_CNT_W,
  parameter int          RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] arg,
  input  logic [WIDTH-1:0] expect_val,
  output logic [WIDTH-1:0] cpu_in,
  output logic             cpu_reset,
  input  logic [WIDTH-1:0] cpu_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] cycles,
`ifdef CPU_RUN_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output run_state_e       dbg_state
);

  localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);

  run_state_e       r_state;
  run_state_e       w_state_next;
  logic             w_accept;
  logic             w_finish;
  logic             w_pass_next;
  logic [7:0]       r_rst_cnt;
  logic [WIDTH-1:0] r_expect;
  logic [WIDTH-1:0] r_cpu_in;
  logic [WIDTH-1:0] r_result;
  logic             r_cpu_reset;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] w_count;
  logic             w_at_limit;

  run_cycle_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_cycle_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_accept),
    .en       (r_state == ST_RUN),
    .count    (w_count),
    .at_limit (w_at_limit)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_pass_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RST;
        end
      end
      ST_RST: begin
`ifdef CPU_RUN_CTRL_ABORT_EN
        if (abort) begin
          w_finish     = 1'b1;
          w_state_next = ST_DONE;
        end else
`endif
        if (r_rst_cnt == RST_LAST) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Priority: abort, then match, then timeout.
`ifdef CPU_RUN_CTRL_ABORT_EN
        if (abort) begin
          w_finish     = 1'b1;
          w_state_next = ST_DONE;
        end else
`endif
        if (cpu_out == r_expect) begin
          w_finish     = 1'b1;
          w_pass_next  = 1'b1;
          w_state_next = ST_DONE;
        end else if (w_at_limit) begin
          w_finish     = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cpu_reset <= 1'b1;
      r_cpu_in    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_result    <= '0;
      r_expect    <= '0;
      r_rst_cnt   <= '0;
    end else begin
      r_state     <= w_state_next;
      // Status flags are decoded from the next state so they are registered
      // and line up with the state they describe.
      r_cpu_reset <= (w_state_next == ST_IDLE) || (w_state_next == ST_RST);
      r_busy      <= (w_state_next == ST_RST) || (w_state_next == ST_RUN);
      r_done      <= (w_state_next == ST_DONE);
      if (r_state == ST_RST) begin
        r_rst_cnt <= r_rst_cnt + 8'd1;
      end
      if (w_accept) begin
        r_cpu_in  <= arg;
        r_expect  <= expect_val;
        r_pass    <= 1'b0;
        r_rst_cnt <= '0;
      end
      if (w_finish) begin
        r_result <= cpu_out;
        r_pass   <= w_pass_next;
      end
    end
  end

  assign cpu_in    = r_cpu_in;
  assign cpu_reset = r_cpu_reset;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign result    = r_result;
  assign cycles    = w_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl -- directed and randomized checks of cpu_run_ctrl.
// Two instances differ only in TIMEOUT (100 and 41); sel routes the shared
// start request to one of them and muxes its outputs for checking.
// Each DUT drives a CPU stub: while out of reset, out=0 for the first N
// cycles, then out = cpu_in ^ stub_key.
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  localparam int TMO_A  = 100;
  localparam int TMO_B  = 41;
  localparam int BUDGET = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        abort_a = 1'b0;
  logic [15:0] arg = '0;
  logic [15:0] expect_val = '0;
  logic [15:0] stub_key = '0;
  int unsigned stub_n = 1;

  logic [15:0] cpu_in_a, cpu_in_b, cpu_out_a = '0, cpu_out_b = '0;
  logic [15:0] result_a, result_b;
  logic [31:0] cycles_a, cycles_b;
  logic        cpu_reset_a, cpu_reset_b, busy_a, busy_b;
  logic        done_a, done_b, pass_a, pass_b;
  run_state_e  dbg_a, dbg_b;
  int unsigned st_cnt_a = 0, st_cnt_b = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.WIDTH(16), .CNT_W(32), .RESET_CYCLES(2), .TIMEOUT(TMO_A)) dut_a (
    .clk(clk), .reset(reset), .start(start & ~sel), .arg(arg), .expect_val(expect_val),
    .cpu_in(cpu_in_a), .cpu_reset(cpu_reset_a), .cpu_out(cpu_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .result(result_a), .cycles(cycles_a),
`ifdef CPU_RUN_CTRL_ABORT_EN
    .abort(abort_a),
`endif
    .dbg_state(dbg_a)
  );

  cpu_run_ctrl #(.WIDTH(16), .CNT_W(32), .RESET_CYCLES(2), .TIMEOUT(TMO_B)) dut_b (
    .clk(clk), .reset(reset), .start(start & sel), .arg(arg), .expect_val(expect_val),
    .cpu_in(cpu_in_b), .cpu_reset(cpu_reset_b), .cpu_out(cpu_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .result(result_b), .cycles(cycles_b),
`ifdef CPU_RUN_CTRL_ABORT_EN
    .abort(1'b0),
`endif
    .dbg_state(dbg_b)
  );

  // CPU stubs
  always_ff @(posedge clk) begin
    if (cpu_reset_a) begin
      st_cnt_a  <= 0;
      cpu_out_a <= '0;
    end else begin
      st_cnt_a  <= st_cnt_a + 1;
      cpu_out_a <= (st_cnt_a + 1 >= stub_n) ? (cpu_in_a ^ stub_key) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_reset_b) begin
      st_cnt_b  <= 0;
      cpu_out_b <= '0;
    end else begin
      st_cnt_b  <= st_cnt_b + 1;
      cpu_out_b <= (st_cnt_b + 1 >= stub_n) ? (cpu_in_b ^ stub_key) : '0;
    end
  end

  // Observed signals of the selected instance
  wire [15:0] cpu_in_s    = sel ? cpu_in_b    : cpu_in_a;
  wire [15:0] result_s    = sel ? result_b    : result_a;
  wire [31:0] cycles_s    = sel ? cycles_b    : cycles_a;
  wire        cpu_reset_s = sel ? cpu_reset_b : cpu_reset_a;
  wire        busy_s      = sel ? busy_b      : busy_a;
  wire        done_s      = sel ? done_b      : done_a;
  wire        pass_s      = sel ? pass_b      : pass_a;
  wire [1:0]  dbg_s       = sel ? dbg_b       : dbg_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: the stub shows 0 in RUN cycles 1..n and val afterwards.
  // The run ends at the first RUN cycle whose output equals the expected
  // value, or at cycle tmo if that comes first (a match on cycle tmo wins).
  function automatic void model(input logic [15:0] a, e, key, input int n, tmo,
                                output int k, output bit p, output logic [15:0] res);
    logic [15:0] val;
    int mk;
    val = a ^ key;
    if (e == 16'h0)    mk = 1;
    else if (val == e) mk = n + 1;
    else               mk = 32'h7fffffff;
    if (mk <= tmo) begin
      k = mk; p = 1'b1; res = e;
    end else begin
      k = tmo; p = 1'b0; res = (tmo > n) ? val : 16'h0;
    end
  endfunction

  task automatic run_one(input bit s, input logic [15:0] a, e, key, input int n, input bit hold);
    int k, lat, rst_hi;
    bit p;
    logic [15:0] res;
    sel = s; arg = a; expect_val = e; stub_key = key; stub_n = n;
    model(a, e, key, n, s ? TMO_B : TMO_A, k, p, res);
    chk("idle_busy", busy_s, 1'b0);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    chk("accept_cpu_in", cpu_in_s, a);
    chk("accept_busy", busy_s, 1'b1);
    chk("accept_clear", {pass_s, cycles_s}, 33'h0);
    lat = 0;
    rst_hi = cpu_reset_s ? 1 : 0;
    while (done_s !== 1'b1 && lat < BUDGET) begin
      tick();
      lat++;
      if (cpu_reset_s === 1'b1 && done_s !== 1'b1) rst_hi++;
    end
    chk("done_latency", lat, k + 2);
    chk("cpu_reset_cycles", rst_hi, 2);
    chk("pass", pass_s, p);
    chk("result", result_s, res);
    chk("cycles", cycles_s, k);
    chk("done_busy", busy_s, 1'b0);
    tick();
    chk("done_single", done_s, 1'b0);
    chk("idle_cpu_reset", cpu_reset_s, 1'b1);
    chk("hold_results", {pass_s, result_s, cycles_s, cpu_in_s}, {p, res, 32'(k), a});
  endtask

  initial begin
    int lat, dones;
    // Reset values of both instances
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #0;
      chk("rst_outputs", {cpu_reset_s, busy_s, done_s, pass_s}, 4'b1000);
      chk("rst_data", {cpu_in_s, result_s, cycles_s}, 64'h0);
      chk("rst_state", dbg_s, ST_IDLE);
    end
    reset = 1'b0;
    sel = 1'b0;
    tick();

    // Match at RUN cycle 41
    run_one(1'b0, 16'h13B0, 16'h000B, 16'h13B0 ^ 16'h000B, 40, 1'b0);
    // Never matches, times out at 100
    run_one(1'b0, 16'h0906, 16'd13, 16'h0000, 40, 1'b0);
    // Match and timeout in the same cycle
    run_one(1'b1, 16'h2222, 16'h5A5A, 16'h2222 ^ 16'h5A5A, 40, 1'b0);

    // start held high through a whole run: one run, then a new one right after IDLE
    run_one(1'b0, 16'h754E, 16'd17, 16'h754E ^ 16'd17, 20, 1'b1);
    tick();
    chk("restart_busy", busy_s, 1'b1);
    start = 1'b0;
    lat = 0;
    while (done_s !== 1'b1 && lat < BUDGET) begin
      tick();
      lat++;
    end
    chk("restart_cycles", cycles_s, 21);
    tick();

    // Reset in the middle of a run
    sel = 1'b0; arg = 16'h4444; expect_val = 16'h0001; stub_key = 16'h4445; stub_n = 40;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    chk("midrun_state", dbg_s, ST_RUN);
    chk("midrun_cycles", cycles_s, 9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_outputs", {cpu_reset_s, busy_s, done_s, pass_s}, 4'b1000);
    chk("midrst_data", {cpu_in_s, result_s, cycles_s}, 64'h0);
    dones = 0;
    repeat (60) begin
      tick();
      if (done_s === 1'b1) dones++;
    end
    chk("midrst_no_done", dones, 0);

`ifdef CPU_RUN_CTRL_ABORT_EN
    // Abort at RUN cycle 5
    sel = 1'b0; arg = 16'h1234; expect_val = 16'h0F0F; stub_key = 16'h00FF; stub_n = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_done", done_s, 1'b1);
    chk("abort_pass", pass_s, 1'b0);
    chk("abort_cycles", cycles_s, 5);
    chk("abort_result", result_s, 16'h1234 ^ 16'h00FF);
    tick();
`endif

    // Randomized runs
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a, e, key;
      a = 16'($urandom);
      e = 16'($urandom);
      key = ($urandom_range(0, 1) == 1) ? (a ^ e) : 16'($urandom);
      run_one(1'($urandom_range(0, 1)), a, e, key, int'($urandom_range(1, 120)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
